// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_VAL    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: pull 3 back out of any digit >= 8.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= ADJ_THRESH) ? din - ADJ_VAL : din;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one shift per clock with start/busy/done.
// Optional invalid-digit detection is enabled by defining BCD_DIGIT_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for start; bcd_in loaded on acceptance
// SHIFT | one right shift plus digit correction per cycle
// DONE  | publish result; done pulses in the following cycle
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state, state_nxt;
  logic [BCD_W-1:0]   bcd_reg, bcd_shr, bcd_adj;
  logic [BIN_W-1:0]   bin_reg, bin_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               bad_in, bad_reg;
  logic               load, shift_en, finish;

  assign bcd_shr = bcd_reg >> 1;
  assign bin_nxt = {bcd_reg[0], bin_reg[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_shr[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

`ifdef BCD_DIGIT_CHECK_EN
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > DIGIT_MAX) bad_in = 1'b1;
    end
  end

  // Invalid input bypasses SHIFT; the flag rides along to DONE.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      bad_reg <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (load)   bad_reg <= bad_in;
      if (finish) err     <= bad_reg;
    end
  end
`else
  assign bad_in  = 1'b0;
  assign bad_reg = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = bad_in ? DONE : SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load     = (state == IDLE) && start;
    shift_en = (state == SHIFT);
    finish   = (state == DONE);
    busy     = (state == SHIFT);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      bin_out <= '0;
      done    <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        bcd_reg <= bcd_in;
        bin_reg <= '0;
        cnt     <= CNT_W'(BIN_W);
      end else if (shift_en) begin
        bcd_reg <= bcd_adj;
        bin_reg <= bin_nxt;
        cnt     <= cnt - CNT_W'(1);
      end
      if (finish) bin_out <= bad_reg ? '0 : bin_reg;
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: a driver queues expected results,
// a monitor pops them on every done pulse and compares value, err, latency, busy.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;
  localparam int PER    = 10;

  logic             CLOCK_50;
  logic             reset_n;
  logic             start;
  logic [11:0]      bcd_in;
  logic             busy;
  logic             done;
  logic [BIN_W-1:0] bin_out;
  logic             err;

  typedef struct {
    logic [11:0] bcd;
    int          exp_bin;
    bit          exp_err;
    bit          check_bin;
    int          lat;
    int          busy_n;
    time         t_acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_cnt = 0;
  int   last_bin = 0;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .start    (start),
    .bcd_in   (bcd_in),
    .busy     (busy),
    .done     (done),
    .bin_out  (bin_out),
    .err      (err)
  );

  initial CLOCK_50 = 1'b0;
  always #(PER/2) CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit bcd_ok(input logic [11:0] b);
    return (b[11:8] <= 4'd9) && (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic int bcd_val(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'((v / 100) % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  // Valid conversions: done 11 edges after the accepting edge, 10 busy cycles.
  function automatic exp_t make_exp(input logic [11:0] b);
    exp_t e;
    e.bcd       = b;
    e.exp_bin   = bcd_val(b);
    e.exp_err   = 1'b0;
    e.check_bin = 1'b1;
    e.lat       = BIN_W + 1;
    e.busy_n    = BIN_W;
    e.t_acc     = 0;
    if (!bcd_ok(b)) begin
`ifdef BCD_DIGIT_CHECK_EN
      e.exp_bin = 0;
      e.exp_err = 1'b1;
      e.lat     = 1;
      e.busy_n  = 0;
`else
      e.check_bin = 1'b0;
`endif
    end
    return e;
  endfunction

  // Called at a negedge with the DUT idle; start is accepted at the next posedge.
  task automatic issue(input logic [11:0] b);
    exp_t e;
    e       = make_exp(b);
    e.t_acc = $time + PER/2;
    start   = 1'b1;
    bcd_in  = b;
    sb.push_back(e);
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLOCK_50);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge CLOCK_50);
  endtask

  always @(negedge CLOCK_50) begin
    if (!reset_n) begin
      busy_cnt = 0;
      last_bin = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("latency", int'(($time - mon_e.t_acc - PER/2) / PER), mon_e.lat);
          check("err", int'(err), int'(mon_e.exp_err));
          check("busy_cycles", busy_cnt, mon_e.busy_n);
          if (mon_e.check_bin) check("bin_out", int'(bin_out), mon_e.exp_bin);
          if (mon_e.check_bin && !mon_e.exp_err)
            check("round_trip", int'(to_bcd(int'(bin_out))), int'(mon_e.bcd));
        end
        busy_cnt = 0;
        last_bin = int'(bin_out);
      end else begin
        check("bin_hold", int'(bin_out), last_bin);
      end
    end
  end

  initial begin
    logic [11:0] r;
    reset_n = 1'b0;
    start   = 1'b0;
    bcd_in  = '0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_bin", int'(bin_out), 0);
    #21 reset_n = 1'b1;
    @(negedge CLOCK_50);

    issue(12'h999); wait_idle();
    issue(12'h000); wait_idle();
    issue(12'h255); wait_idle();

    // Exhaustive sweep with start held high: one accept every BIN_W+2 cycles.
    start = 1'b1;
    for (int v = 0; v < 1000; v++) begin
      exp_t e;
      bcd_in  = to_bcd(v);
      e       = make_exp(bcd_in);
      e.t_acc = $time + PER/2;
      sb.push_back(e);
      repeat (BIN_W + 2) @(negedge CLOCK_50);
    end
    start = 1'b0;
    wait_idle();

    // Re-pulsed start while busy must be ignored.
    issue(12'h123);
    repeat (2) @(negedge CLOCK_50);
    start  = 1'b1;
    bcd_in = 12'h456;
    @(negedge CLOCK_50);
    start = 1'b0;
    wait_idle();

    // Reset mid-conversion: everything clears, no done for the aborted request.
    issue(12'h871);
    repeat (4) @(negedge CLOCK_50);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_err", int'(err), 0);
    check("abort_bin", int'(bin_out), 0);
    @(negedge CLOCK_50);
    sb.delete();
    @(negedge CLOCK_50);
    #2 reset_n = 1'b1;
    @(negedge CLOCK_50);
    issue(12'h042); wait_idle();

    issue(12'h1A3); wait_idle();
    issue(12'h010); wait_idle();

    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
      if ($urandom_range(0, 7) == 0) r = 12'($urandom);
      else                           r = to_bcd(int'($urandom_range(0, 999)));
      issue(r);
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
